// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Holds the PLL in reset, waits for its lock indication, requires the lock to
// stay up for a number of cycles, and only then releases the system reset.
// Lock timeouts, lock loss and explicit requests all restart the sequence,
// while a small sticky status record (lock lost, retry count) is kept.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 20
) (
    input  logic       CLK50MHZ,
    input  logic       RESET_N,
    input  logic       PLL_LOCKED,
    input  logic       REQ_RESET,
    input  logic       CLR_STATUS,
    output logic       PLL_RST,
    output logic       SYS_RESET_N,
    output logic       LOCK_LOST,
    output logic [7:0] RETRY_CNT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Terminal counter values; each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             locked_s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             req_restart;
    logic             timeout_hit;
    logic             lock_drop;

    // Two-flop synchronizer: the lock signal comes from the PLL's own domain.
    always_ff @(posedge CLK50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], PLL_LOCKED};
        end
    end

    assign locked_s = sync_q[1];

    // Next-state decision: a reset request beats every lock/timeout transition.
    always_comb begin
        next_state  = state;
        req_restart = 1'b0;
        timeout_hit = 1'b0;
        lock_drop   = 1'b0;
        if (REQ_RESET) begin
            next_state  = PLL_RESET;
            req_restart = 1'b1;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (count == RST_LAST) begin
                        next_state = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = STABLE;
                    end else if (count == TIMEOUT_LAST) begin
                        next_state  = PLL_RESET;
                        timeout_hit = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        next_state = WAIT_LOCK;
                    end else if (count == STABLE_LAST) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        next_state = PLL_RESET;
                        lock_drop  = 1'b1;
                    end
                end
                default: begin
                    next_state = PLL_RESET;
                end
            endcase
        end
    end

    // State, phase counter, outputs decoded from the next state, status record.
    always_ff @(posedge CLK50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= PLL_RESET;
            count       <= '0;
            PLL_RST     <= 1'b1;
            SYS_RESET_N <= 1'b0;
            LOCK_LOST   <= 1'b0;
            RETRY_CNT   <= 8'd0;
        end else begin
            state <= next_state;

            if ((next_state != state) || req_restart) begin
                count <= '0;
            end else if (state != RUN) begin
                count <= count + CNT_W'(1);
            end

            PLL_RST     <= (next_state == PLL_RESET);
            SYS_RESET_N <= (next_state == RUN);

            if (lock_drop) begin
                LOCK_LOST <= 1'b1;
            end else if (CLR_STATUS) begin
                LOCK_LOST <= 1'b0;
            end

            if (timeout_hit) begin
                if (CLR_STATUS) begin
                    RETRY_CNT <= 8'd1;
                end else if (RETRY_CNT != 8'hFF) begin
                    RETRY_CNT <= RETRY_CNT + 8'd1;
                end
            end else if (CLR_STATUS) begin
                RETRY_CNT <= 8'd0;
            end
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer using short phase lengths
// (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8). Edge numbers in the
// tasks count clock edges after reset release, starting at 0; an input
// written before edge e is synchronised and acted upon at edge e+2.
module tb_pll_reset_sequencer;

    logic       CLK50MHZ;
    logic       RESET_N;
    logic       PLL_LOCKED;
    logic       REQ_RESET;
    logic       CLR_STATUS;
    logic       PLL_RST;
    logic       SYS_RESET_N;
    logic       LOCK_LOST;
    logic [7:0] RETRY_CNT;
    logic [1:0] STATE;

    int tests_run;
    int tests_failed;

    pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .CNT_W         (20)
    ) dut (
        .CLK50MHZ    (CLK50MHZ),
        .RESET_N     (RESET_N),
        .PLL_LOCKED  (PLL_LOCKED),
        .REQ_RESET   (REQ_RESET),
        .CLR_STATUS  (CLR_STATUS),
        .PLL_RST     (PLL_RST),
        .SYS_RESET_N (SYS_RESET_N),
        .LOCK_LOST   (LOCK_LOST),
        .RETRY_CNT   (RETRY_CNT),
        .STATE       (STATE)
    );

    // 50 MHz reference clock
    initial begin
        CLK50MHZ = 1'b0;
        forever #10 CLK50MHZ = ~CLK50MHZ;
    end

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    // Hold reset for two edges, then release with all inputs idle
    task automatic reset_dut();
        RESET_N    = 1'b0;
        PLL_LOCKED = 1'b0;
        REQ_RESET  = 1'b0;
        CLR_STATUS = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
    endtask

    // Lock present from the start: RUN is reached at edge 12
    task automatic bring_to_run();
        reset_dut();
        PLL_LOCKED = 1'b1;
        repeat (14) tick();
    endtask

    task automatic test_reset();
        RESET_N    = 1'b0;
        PLL_LOCKED = 1'b1;
        REQ_RESET  = 1'b1;
        CLR_STATUS = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (PLL_RST !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_pll_rst: got %0b expected 1", PLL_RST);
        end
        tests_run++;
        if (SYS_RESET_N !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sys_reset_n: got %0b expected 0", SYS_RESET_N);
        end
        tests_run++;
        if (LOCK_LOST !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_lock_lost: got %0b expected 0", LOCK_LOST);
        end
        tests_run++;
        if (RETRY_CNT !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_retry_cnt: got %0d expected 0", RETRY_CNT);
        end
        tests_run++;
        if (STATE !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %0d expected 0", STATE);
        end
        REQ_RESET  = 1'b0;
        PLL_LOCKED = 1'b0;
    endtask

    task automatic test_cold_start();
        logic [1:0] exp_state;
        reset_dut();
        for (int e = 0; e <= 24; e++) begin
            PLL_LOCKED = (e >= 10);
            tick();
            exp_state = (e < 3) ? 2'd0 : (e < 12) ? 2'd1 : (e < 20) ? 2'd2 : 2'd3;
            tests_run++;
            if (STATE !== exp_state) begin
                tests_failed++;
                $display("[TB] FAIL cold_state e=%0d: got %0d expected %0d", e, STATE, exp_state);
            end
            tests_run++;
            if (PLL_RST !== (e < 3)) begin
                tests_failed++;
                $display("[TB] FAIL cold_pll_rst e=%0d: got %0b expected %0b", e, PLL_RST, (e < 3));
            end
            tests_run++;
            if (SYS_RESET_N !== (e >= 20)) begin
                tests_failed++;
                $display("[TB] FAIL cold_sys_reset_n e=%0d: got %0b expected %0b", e, SYS_RESET_N, (e >= 20));
            end
        end
    endtask

    task automatic test_timeout();
        int pulse_edge;
        reset_dut();
        for (int e = 0; e <= 7199; e++) begin
            tick();
            pulse_edge = ((e >= 23) && ((e - 23) % 24 == 0)) ? 1 : 0;
            if (e == 22 || e == 23 || e == 47 || e == 71 || e == 6118 || e == 6119 || e == 7199) begin
                tests_run++;
                if (RETRY_CNT !== ((e < 23) ? 8'd0 : (e < 47) ? 8'd1 : (e < 71) ? 8'd2 :
                                   (e < 6119) ? ((e < 95) ? 8'd3 : 8'd254) : 8'd255)) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_retry e=%0d: got %0d", e, RETRY_CNT);
                end
            end
            if (e == 22 || pulse_edge == 1 && e < 100 || e == 27 || e == 51) begin
                tests_run++;
                if (PLL_RST !== (pulse_edge == 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_pll_rst e=%0d: got %0b expected %0b", e, PLL_RST, (pulse_edge == 1));
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        logic [1:0] exp_state;
        reset_dut();
        for (int e = 0; e <= 28; e++) begin
            PLL_LOCKED = (e >= 10) && !((e >= 14) && (e <= 16));
            tick();
            exp_state = (e < 3) ? 2'd0 : (e < 12) ? 2'd1 : (e < 16) ? 2'd2 :
                        (e < 19) ? 2'd1 : (e < 27) ? 2'd2 : 2'd3;
            tests_run++;
            if (STATE !== exp_state) begin
                tests_failed++;
                $display("[TB] FAIL glitch_state e=%0d: got %0d expected %0d", e, STATE, exp_state);
            end
            tests_run++;
            if (SYS_RESET_N !== (e >= 27)) begin
                tests_failed++;
                $display("[TB] FAIL glitch_sys_reset_n e=%0d: got %0b expected %0b", e, SYS_RESET_N, (e >= 27));
            end
        end
        tests_run++;
        if (RETRY_CNT !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL glitch_retry: got %0d expected 0", RETRY_CNT);
        end
    endtask

    task automatic test_loss_in_run();
        bring_to_run();
        tests_run++;
        if (STATE !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL loss_start_state: got %0d expected 3", STATE);
        end
        PLL_LOCKED = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (SYS_RESET_N !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL loss_early_sys_reset_n: got %0b expected 1", SYS_RESET_N);
        end
        tick();
        tests_run++;
        if ({SYS_RESET_N, PLL_RST, LOCK_LOST, STATE} !== {1'b0, 1'b1, 1'b1, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL loss_outputs: got sys=%0b rst=%0b lost=%0b state=%0d expected sys=0 rst=1 lost=1 state=0",
                     SYS_RESET_N, PLL_RST, LOCK_LOST, STATE);
        end
        tests_run++;
        if (RETRY_CNT !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL loss_retry: got %0d expected 0", RETRY_CNT);
        end
        PLL_LOCKED = 1'b1;
        repeat (12) tick();
        tests_run++;
        if (STATE !== 2'd2 || SYS_RESET_N !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL loss_resequence_stable: got state=%0d sys=%0b expected state=2 sys=0", STATE, SYS_RESET_N);
        end
        tick();
        tests_run++;
        if (STATE !== 2'd3 || SYS_RESET_N !== 1'b1 || LOCK_LOST !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL loss_resequence_run: got state=%0d sys=%0b lost=%0b expected state=3 sys=1 lost=1",
                     STATE, SYS_RESET_N, LOCK_LOST);
        end
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        tests_run++;
        if (LOCK_LOST !== 1'b0 || STATE !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL loss_clear: got lost=%0b state=%0d expected lost=0 state=3", LOCK_LOST, STATE);
        end
    endtask

    task automatic test_req_reset();
        int high;
        bring_to_run();
        high = 0;
        for (int k = 1; k <= 10; k++) begin
            REQ_RESET = (k == 1);
            tick();
            if (PLL_RST === 1'b1) high++;
            if (k == 1) begin
                tests_run++;
                if (STATE !== 2'd0 || SYS_RESET_N !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL req_run_enter: got state=%0d sys=%0b expected state=0 sys=0", STATE, SYS_RESET_N);
                end
            end
        end
        REQ_RESET = 1'b0;
        tests_run++;
        if (high != 4) begin
            tests_failed++;
            $display("[TB] FAIL req_run_pulse: got %0d cycles expected 4", high);
        end
        tests_run++;
        if (LOCK_LOST !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL req_run_lock_lost: got %0b expected 0", LOCK_LOST);
        end
        high = 0;
        for (int k = 1; k <= 12; k++) begin
            REQ_RESET = (k == 1) || (k == 4);
            tick();
            if (PLL_RST === 1'b1) high++;
        end
        REQ_RESET = 1'b0;
        tests_run++;
        if (high != 7) begin
            tests_failed++;
            $display("[TB] FAIL req_extend_pulse: got %0d cycles expected 7", high);
        end
    endtask

    task automatic test_clr_collision();
        reset_dut();
        for (int e = 0; e <= 50; e++) begin
            CLR_STATUS = (e == 47) || (e == 50);
            tick();
            if (e == 46 || e == 47) begin
                tests_run++;
                if (RETRY_CNT !== 8'd1) begin
                    tests_failed++;
                    $display("[TB] FAIL clr_timeout_collision e=%0d: got %0d expected 1", e, RETRY_CNT);
                end
            end
            if (e == 50) begin
                tests_run++;
                if (RETRY_CNT !== 8'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL clr_retry_only: got %0d expected 0", RETRY_CNT);
                end
            end
        end
        CLR_STATUS = 1'b0;
        bring_to_run();
        PLL_LOCKED = 1'b0;
        repeat (2) tick();
        CLR_STATUS = 1'b1;
        tick();
        CLR_STATUS = 1'b0;
        tests_run++;
        if (LOCK_LOST !== 1'b1 || STATE !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL clr_loss_collision: got lost=%0b state=%0d expected lost=1 state=0", LOCK_LOST, STATE);
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int e = 0; e <= 30; e++) tick();
        tests_run++;
        if (STATE !== 2'd1 || PLL_RST !== 1'b0 || RETRY_CNT !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL async_pre: got state=%0d rst=%0b retry=%0d expected state=1 rst=0 retry=1",
                     STATE, PLL_RST, RETRY_CNT);
        end
        #5;
        RESET_N = 1'b0;
        #1;
        tests_run++;
        if (PLL_RST !== 1'b1 || SYS_RESET_N !== 1'b0 || STATE !== 2'd0 || RETRY_CNT !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_assert: got rst=%0b sys=%0b state=%0d retry=%0d expected rst=1 sys=0 state=0 retry=0",
                     PLL_RST, SYS_RESET_N, STATE, RETRY_CNT);
        end
        #2;
        RESET_N = 1'b1;
        for (int e = 0; e <= 3; e++) begin
            tick();
            tests_run++;
            if (STATE !== ((e < 3) ? 2'd0 : 2'd1)) begin
                tests_failed++;
                $display("[TB] FAIL async_restart e=%0d: got %0d expected %0d", e, STATE, (e < 3) ? 0 : 1);
            end
        end
        bring_to_run();
        #5;
        RESET_N = 1'b0;
        #1;
        tests_run++;
        if (SYS_RESET_N !== 1'b0 || PLL_RST !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL async_from_run: got sys=%0b rst=%0b expected sys=0 rst=1", SYS_RESET_N, PLL_RST);
        end
        #2;
        RESET_N = 1'b1;
    endtask

    // Scenario sequence
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RESET_N      = 1'b0;
        PLL_LOCKED   = 1'b0;
        REQ_RESET    = 1'b0;
        CLR_STATUS   = 1'b0;
        test_reset();
        test_cold_start();
        test_timeout();
        test_lock_glitch();
        test_loss_in_run();
        test_req_reset();
        test_clr_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
